// File: rtl/fpu_issue_seq_pkg.sv
// Shared definitions for the FP issue sequencer: select codes, FSM state
// encoding and the mapping from select code to FPU latency.
package fpu_issue_seq_pkg;

  // FPU select codes; the FPU decoder uses the same values
  localparam logic [4:0] SEL_FADD  = 5'd0;
  localparam logic [4:0] SEL_FSUB  = 5'd1;
  localparam logic [4:0] SEL_FMUL  = 5'd2;
  localparam logic [4:0] SEL_FDIV  = 5'd3;
  localparam logic [4:0] SEL_FSQRT = 5'd4;

  // Default latencies, in cycles from the issue edge to the first writeback cycle
  localparam int unsigned DEF_LAT_ADD  = 3;
  localparam int unsigned DEF_LAT_MUL  = 4;
  localparam int unsigned DEF_LAT_DIV  = 12;
  localparam int unsigned DEF_LAT_SQRT = 16;
  localparam int unsigned DEF_CNT_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Latency class of an operation; anything not in the multi-cycle set
  // (sign-inject, min/max, compare, move, convert) completes in one cycle
  function automatic int unsigned fpu_latency(input logic [4:0] sel,
                                              input int unsigned latAdd,
                                              input int unsigned latMul,
                                              input int unsigned latDiv,
                                              input int unsigned latSqrt);
    case (sel)
      SEL_FADD, SEL_FSUB: return latAdd;
      SEL_FMUL:           return latMul;
      SEL_FDIV:           return latDiv;
      SEL_FSQRT:          return latSqrt;
      default:            return 1;
    endcase
  endfunction

endpackage

// File: rtl/fpu_issue_seq_if.sv
// Pipeline-facing bundle of the FP issue sequencer. Signal suffixes are
// written from the sequencer's point of view.
interface fpu_issue_seq_if;
  logic       issue_valid_i;
  logic       issue_ready_o;
  logic [4:0] sel_i;
  logic [4:0] rd_i;
  logic       we_i;
  logic [4:0] rs1_i;
  logic [4:0] rs2_i;
  logic [4:0] rs3_i;
  logic       rs_fp_i;
  logic       flush_i;
  logic       fpu_start_o;
  logic [4:0] fpu_sel_o;
  logic       busy_o;
  logic       stall_o;
  logic       hazard_o;
  logic       wb_valid_o;
  logic       wb_ready_i;
  logic [4:0] wb_rd_o;
  logic       wb_we_o;

  // The sequencer itself
  modport slave (
    input  issue_valid_i, sel_i, rd_i, we_i, rs1_i, rs2_i, rs3_i, rs_fp_i,
           flush_i, wb_ready_i,
    output issue_ready_o, fpu_start_o, fpu_sel_o, busy_o, stall_o, hazard_o,
           wb_valid_o, wb_rd_o, wb_we_o
  );

  // The pipeline side that issues ops and consumes writebacks
  modport master (
    output issue_valid_i, sel_i, rd_i, we_i, rs1_i, rs2_i, rs3_i, rs_fp_i,
           flush_i, wb_ready_i,
    input  issue_ready_o, fpu_start_o, fpu_sel_o, busy_o, stall_o, hazard_o,
           wb_valid_o, wb_rd_o, wb_we_o
  );
endinterface

// File: rtl/fpu_lat_counter.sv
// Latency down counter: loads LAT-1 on issue, counts down while the op is
// in flight and flags the last busy cycle. It stops at zero rather than wrap.
module fpu_lat_counter #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             one_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: a load wins over a decrement, and zero is sticky
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - CNT_W'(1);
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/fpu_issue_seq.sv
// FP issue sequencer: holds one FP op for its class latency, presents the
// result to FP writeback, and reports stalls and RAW hazards to the pipeline.
module fpu_issue_seq
  import fpu_issue_seq_pkg::*;
#(
  parameter int unsigned LAT_ADD  = DEF_LAT_ADD,
  parameter int unsigned LAT_MUL  = DEF_LAT_MUL,
  parameter int unsigned LAT_DIV  = DEF_LAT_DIV,
  parameter int unsigned LAT_SQRT = DEF_LAT_SQRT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input logic             clk,
  input logic             rst_n,
  fpu_issue_seq_if.slave  bus
);

  seq_state_e       state_q;
  logic [4:0]       sel_q;
  logic [4:0]       rd_q;
  logic             we_q;

  int unsigned      opLat;
  logic [CNT_W-1:0] latMinus1;
  logic             latIsOne;
  logic             issueReady;
  logic             issueFire;
  logic             cntOne;
  logic             busy;
  logic             srcMatch;

  // Latency of the op currently offered by decode
  always_comb begin
    opLat     = fpu_latency(bus.sel_i, LAT_ADD, LAT_MUL, LAT_DIV, LAT_SQRT);
    latMinus1 = CNT_W'(opLat - 32'd1);
    latIsOne  = (opLat == 32'd1);
  end

  // Ready in IDLE, or in DONE when the result leaves this cycle; held low in reset
  assign issueReady = rst_n && ((state_q == ST_IDLE) ||
                                ((state_q == ST_DONE) && bus.wb_ready_i));
  assign issueFire  = bus.issue_valid_i && issueReady && !bus.flush_i;

  fpu_lat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (issueFire),
    .load_val_i(latMinus1),
    .dec_i     (state_q == ST_BUSY),
    .one_o     (cntOne)
  );

  // Sequencer FSM plus the latched op; flush beats writeback completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
    end else if (issueFire) begin
      sel_q   <= bus.sel_i;
      rd_q    <= bus.rd_i;
      we_q    <= bus.we_i;
      state_q <= latIsOne ? ST_DONE : ST_BUSY;
    end else if (bus.flush_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_BUSY: if (cntOne) state_q <= ST_DONE;
        ST_DONE: if (bus.wb_ready_i) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign srcMatch = (bus.rs1_i == rd_q) || (bus.rs2_i == rd_q) ||
                    (bus.rs3_i == rd_q);

  assign bus.issue_ready_o = issueReady;
  assign bus.fpu_start_o   = issueFire;
  assign bus.fpu_sel_o     = sel_q;
  assign bus.busy_o        = busy;
  assign bus.stall_o       = rst_n && bus.issue_valid_i && !issueReady;
  assign bus.hazard_o      = busy && we_q && bus.rs_fp_i && srcMatch;
  assign bus.wb_valid_o    = (state_q == ST_DONE) && !bus.flush_i;
  assign bus.wb_rd_o       = rd_q;
  assign bus.wb_we_o       = bus.wb_valid_o && we_q;

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Directed testbench for the FP issue sequencer. Cycle k means k rising
// edges after the issue cycle; outputs are sampled 2 time units after an edge.
module tb_fpu_issue_seq;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  fpu_issue_seq_if bus ();

  fpu_issue_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return every pipeline-side input to its quiet value
  task automatic quietInputs();
    bus.issue_valid_i = 1'b0;
    bus.sel_i = 5'd0;
    bus.rd_i = 5'd0;
    bus.we_i = 1'b0;
    bus.rs1_i = 5'd0;
    bus.rs2_i = 5'd0;
    bus.rs3_i = 5'd0;
    bus.rs_fp_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.wb_ready_i = 1'b0;
  endtask

  // Drive one decoded op onto the issue port
  task automatic offerOp(input logic [4:0] sel, input logic [4:0] rd, input logic we);
    bus.issue_valid_i = 1'b1;
    bus.sel_i = sel;
    bus.rd_i = rd;
    bus.we_i = we;
  endtask

  // Reset drives every output low, then the sequencer comes up ready
  task automatic test_reset();
    quietInputs();
    rst_n = 1'b0;
    #3;
    testsRun++; if (bus.issue_ready_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.issue_ready_o); end
    testsRun++; if ({bus.busy_o, bus.wb_valid_o, bus.wb_we_o, bus.fpu_start_o, bus.hazard_o, bus.stall_o} !== 6'b0) begin testsFailed++; $display("[TB] FAIL reset_flags: got %b expected 000000", {bus.busy_o, bus.wb_valid_o, bus.wb_we_o, bus.fpu_start_o, bus.hazard_o, bus.stall_o}); end
    testsRun++; if ({bus.fpu_sel_o, bus.wb_rd_o} !== 10'd0) begin testsFailed++; $display("[TB] FAIL reset_regs: got %h expected 000", {bus.fpu_sel_o, bus.wb_rd_o}); end
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    testsRun++; if (bus.issue_ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_release_ready: got %b expected 1", bus.issue_ready_o); end
  endtask

  // FMUL: start pulse at cycle 0, blocked cycles 1-3, result at cycle 4
  task automatic test_fmul();
    quietInputs();
    offerOp(5'd2, 5'd5, 1'b1);
    #1;
    testsRun++; if (bus.fpu_start_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL fmul_start: got %b expected 1", bus.fpu_start_o); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      bus.issue_valid_i = 1'b0;
      #1;
      testsRun++; if ({bus.issue_ready_o, bus.wb_valid_o, bus.fpu_start_o, bus.busy_o} !== 4'b0001) begin testsFailed++; $display("[TB] FAIL fmul_busy_c%0d: got rdy/val/start/busy=%b expected 0001", c, {bus.issue_ready_o, bus.wb_valid_o, bus.fpu_start_o, bus.busy_o}); end
    end
    tick();
    #1;
    testsRun++; if (bus.wb_valid_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL fmul_wb_valid_c4: got %b expected 1", bus.wb_valid_o); end
    testsRun++; if ({bus.wb_rd_o, bus.wb_we_o, bus.fpu_sel_o} !== {5'd5, 1'b1, 5'd2}) begin testsFailed++; $display("[TB] FAIL fmul_wb_fields: got rd=%0d we=%b sel=%0d expected rd=5 we=1 sel=2", bus.wb_rd_o, bus.wb_we_o, bus.fpu_sel_o); end
    bus.wb_ready_i = 1'b1;
    #1;
    testsRun++; if (bus.issue_ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL fmul_done_ready: got %b expected 1", bus.issue_ready_o); end
    tick();
    bus.wb_ready_i = 1'b0;
    #1;
    testsRun++; if ({bus.busy_o, bus.wb_valid_o} !== 2'b00) begin testsFailed++; $display("[TB] FAIL fmul_idle_after_wb: got busy/val=%b expected 00", {bus.busy_o, bus.wb_valid_o}); end
  endtask

  // FSGNJ completes at cycle 1; an FADD issued in that writeback cycle is accepted
  task automatic test_back_to_back();
    quietInputs();
    bus.wb_ready_i = 1'b1;
    offerOp(5'd8, 5'd3, 1'b1);
    #1;
    testsRun++; if (bus.fpu_start_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_start1: got %b expected 1", bus.fpu_start_o); end
    tick();
    offerOp(5'd0, 5'd9, 1'b1);
    #1;
    testsRun++; if ({bus.wb_valid_o, bus.wb_rd_o} !== {1'b1, 5'd3}) begin testsFailed++; $display("[TB] FAIL b2b_fsgnj_wb: got val=%b rd=%0d expected val=1 rd=3", bus.wb_valid_o, bus.wb_rd_o); end
    testsRun++; if ({bus.issue_ready_o, bus.fpu_start_o, bus.stall_o} !== 3'b110) begin testsFailed++; $display("[TB] FAIL b2b_second_issue: got rdy/start/stall=%b expected 110", {bus.issue_ready_o, bus.fpu_start_o, bus.stall_o}); end
    tick();
    bus.issue_valid_i = 1'b0;
    #1;
    testsRun++; if ({bus.busy_o, bus.wb_valid_o, bus.fpu_sel_o} !== {1'b1, 1'b0, 5'd0}) begin testsFailed++; $display("[TB] FAIL b2b_fadd_busy: got busy=%b val=%b sel=%0d expected busy=1 val=0 sel=0", bus.busy_o, bus.wb_valid_o, bus.fpu_sel_o); end
    tick();
    #1;
    testsRun++; if (bus.wb_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_fadd_c3: got %b expected 0", bus.wb_valid_o); end
    tick();
    #1;
    testsRun++; if ({bus.wb_valid_o, bus.wb_rd_o, bus.wb_we_o} !== {1'b1, 5'd9, 1'b1}) begin testsFailed++; $display("[TB] FAIL b2b_fadd_wb_c4: got val=%b rd=%0d we=%b expected val=1 rd=9 we=1", bus.wb_valid_o, bus.wb_rd_o, bus.wb_we_o); end
    tick();
    bus.wb_ready_i = 1'b0;
    #1;
    testsRun++; if (bus.busy_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_idle: got %b expected 0", bus.busy_o); end
  endtask

  // FDIV rd=7 with ID reading f7: hazard through the writeback cycle, gone after
  task automatic test_hazard();
    quietInputs();
    bus.rs2_i = 5'd7;
    bus.rs_fp_i = 1'b1;
    offerOp(5'd3, 5'd7, 1'b1);
    #1;
    testsRun++; if (bus.hazard_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL haz_issue_cycle: got %b expected 0", bus.hazard_o); end
    for (int c = 1; c <= 11; c++) begin
      tick();
      bus.issue_valid_i = 1'b0;
      bus.rs_fp_i = (c == 5) ? 1'b0 : 1'b1;
      #1;
      if (c == 5) begin
        testsRun++; if (bus.hazard_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL haz_no_fp_read: got %b expected 0", bus.hazard_o); end
      end else begin
        testsRun++; if ({bus.hazard_o, bus.wb_valid_o} !== 2'b10) begin testsFailed++; $display("[TB] FAIL haz_busy_c%0d: got haz/val=%b expected 10", c, {bus.hazard_o, bus.wb_valid_o}); end
      end
    end
    tick();
    bus.wb_ready_i = 1'b1;
    #1;
    testsRun++; if ({bus.hazard_o, bus.wb_valid_o} !== 2'b11) begin testsFailed++; $display("[TB] FAIL haz_wb_cycle_c12: got haz/val=%b expected 11", {bus.hazard_o, bus.wb_valid_o}); end
    tick();
    bus.wb_ready_i = 1'b0;
    #1;
    testsRun++; if (bus.hazard_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL haz_after_wb: got %b expected 0", bus.hazard_o); end
  endtask

  // Result held under writeback back-pressure; a waiting issue stalls, then issues when granted
  task automatic test_stall();
    quietInputs();
    bus.rs1_i = 5'd4;
    bus.rs_fp_i = 1'b1;
    offerOp(5'd2, 5'd4, 1'b0);
    tick();
    bus.issue_valid_i = 1'b0;
    tick();
    tick();
    tick();
    offerOp(5'd1, 5'd6, 1'b1);
    for (int c = 4; c <= 6; c++) begin
      #1;
      testsRun++; if ({bus.wb_valid_o, bus.wb_rd_o, bus.wb_we_o} !== {1'b1, 5'd4, 1'b0}) begin testsFailed++; $display("[TB] FAIL stall_hold_c%0d: got val=%b rd=%0d we=%b expected val=1 rd=4 we=0", c, bus.wb_valid_o, bus.wb_rd_o, bus.wb_we_o); end
      testsRun++; if ({bus.stall_o, bus.issue_ready_o, bus.fpu_start_o, bus.hazard_o} !== 4'b1000) begin testsFailed++; $display("[TB] FAIL stall_flags_c%0d: got stall/rdy/start/haz=%b expected 1000", c, {bus.stall_o, bus.issue_ready_o, bus.fpu_start_o, bus.hazard_o}); end
      tick();
    end
    bus.wb_ready_i = 1'b1;
    #1;
    testsRun++; if ({bus.stall_o, bus.issue_ready_o, bus.fpu_start_o} !== 3'b011) begin testsFailed++; $display("[TB] FAIL stall_release: got stall/rdy/start=%b expected 011", {bus.stall_o, bus.issue_ready_o, bus.fpu_start_o}); end
    tick();
    bus.issue_valid_i = 1'b0;
    bus.wb_ready_i = 1'b0;
    #1;
    testsRun++; if ({bus.busy_o, bus.wb_valid_o, bus.fpu_sel_o} !== {1'b1, 1'b0, 5'd1}) begin testsFailed++; $display("[TB] FAIL stall_fsub_busy: got busy=%b val=%b sel=%0d expected busy=1 val=0 sel=1", bus.busy_o, bus.wb_valid_o, bus.fpu_sel_o); end
    tick();
    tick();
    #1;
    testsRun++; if ({bus.wb_valid_o, bus.wb_rd_o, bus.wb_we_o} !== {1'b1, 5'd6, 1'b1}) begin testsFailed++; $display("[TB] FAIL stall_fsub_wb: got val=%b rd=%0d we=%b expected val=1 rd=6 we=1", bus.wb_valid_o, bus.wb_rd_o, bus.wb_we_o); end
    bus.wb_ready_i = 1'b1;
    tick();
    bus.wb_ready_i = 1'b0;
  endtask

  // Flush in BUSY, in IDLE alongside an issue, and in DONE against a granted writeback
  task automatic test_flush();
    int seenValid;
    quietInputs();
    bus.wb_ready_i = 1'b1;
    offerOp(5'd4, 5'd2, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      tick();
      bus.issue_valid_i = 1'b0;
    end
    bus.flush_i = 1'b1;
    offerOp(5'd2, 5'd11, 1'b1);
    #1;
    testsRun++; if ({bus.wb_valid_o, bus.fpu_start_o} !== 2'b00) begin testsFailed++; $display("[TB] FAIL flush_busy_cycle: got val/start=%b expected 00", {bus.wb_valid_o, bus.fpu_start_o}); end
    tick();
    bus.flush_i = 1'b0;
    bus.issue_valid_i = 1'b0;
    #1;
    testsRun++; if ({bus.busy_o, bus.issue_ready_o} !== 2'b01) begin testsFailed++; $display("[TB] FAIL flush_to_idle: got busy/rdy=%b expected 01", {bus.busy_o, bus.issue_ready_o}); end
    seenValid = 0;
    for (int c = 8; c <= 20; c++) begin
      tick();
      if (bus.wb_valid_o === 1'b1 || bus.busy_o === 1'b1) seenValid++;
    end
    testsRun++; if (seenValid !== 0) begin testsFailed++; $display("[TB] FAIL flush_no_wb: got %0d active cycles expected 0", seenValid); end
    offerOp(5'd2, 5'd12, 1'b1);
    bus.flush_i = 1'b1;
    #1;
    testsRun++; if (bus.fpu_start_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_drops_issue_start: got %b expected 0", bus.fpu_start_o); end
    tick();
    bus.flush_i = 1'b0;
    bus.wb_ready_i = 1'b0;
    offerOp(5'd9, 5'd13, 1'b1);
    #1;
    testsRun++; if ({bus.busy_o, bus.fpu_sel_o} !== {1'b0, 5'd4}) begin testsFailed++; $display("[TB] FAIL flush_drops_issue: got busy=%b sel=%0d expected busy=0 sel=4", bus.busy_o, bus.fpu_sel_o); end
    tick();
    bus.issue_valid_i = 1'b0;
    bus.flush_i = 1'b1;
    bus.wb_ready_i = 1'b1;
    #1;
    testsRun++; if ({bus.busy_o, bus.wb_valid_o, bus.wb_we_o} !== 3'b100) begin testsFailed++; $display("[TB] FAIL flush_done_masks_wb: got busy/val/we=%b expected 100", {bus.busy_o, bus.wb_valid_o, bus.wb_we_o}); end
    tick();
    bus.flush_i = 1'b0;
    bus.wb_ready_i = 1'b0;
    #1;
    testsRun++; if ({bus.busy_o, bus.wb_valid_o} !== 2'b00) begin testsFailed++; $display("[TB] FAIL flush_done_to_idle: got busy/val=%b expected 00", {bus.busy_o, bus.wb_valid_o}); end
  endtask

  // Asynchronous reset mid-FDIV clears everything at once and no writeback follows
  task automatic test_async_reset();
    int seenValid;
    quietInputs();
    bus.rs3_i = 5'd14;
    bus.rs_fp_i = 1'b1;
    offerOp(5'd3, 5'd14, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.issue_valid_i = 1'b0;
    end
    #1;
    testsRun++; if ({bus.busy_o, bus.hazard_o} !== 2'b11) begin testsFailed++; $display("[TB] FAIL areset_pre_busy: got busy/haz=%b expected 11", {bus.busy_o, bus.hazard_o}); end
    #1 rst_n = 1'b0;
    #1;
    testsRun++; if ({bus.busy_o, bus.hazard_o, bus.wb_valid_o, bus.issue_ready_o, bus.fpu_start_o} !== 5'b0) begin testsFailed++; $display("[TB] FAIL areset_flags: got busy/haz/val/rdy/start=%b expected 00000", {bus.busy_o, bus.hazard_o, bus.wb_valid_o, bus.issue_ready_o, bus.fpu_start_o}); end
    testsRun++; if ({bus.fpu_sel_o, bus.wb_rd_o} !== 10'd0) begin testsFailed++; $display("[TB] FAIL areset_regs: got %h expected 000", {bus.fpu_sel_o, bus.wb_rd_o}); end
    tick();
    #2 rst_n = 1'b1;
    bus.wb_ready_i = 1'b1;
    seenValid = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (bus.wb_valid_o === 1'b1 || bus.busy_o === 1'b1) seenValid++;
    end
    testsRun++; if (seenValid !== 0) begin testsFailed++; $display("[TB] FAIL areset_no_wb: got %0d active cycles expected 0", seenValid); end
  endtask

  // Scenario sequence
  initial begin
    testsRun = 0;
    testsFailed = 0;
    rst_n = 1'b0;
    quietInputs();
    test_reset();
    tick();
    test_fmul();
    test_back_to_back();
    test_hazard();
    test_stall();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fpu_issue_seq.md
Name: fpu_issue_seq

Overview:
- Sequences the multi-cycle FPU for the RISC-V pipeline: accepts one decoded FP operation (FPU select code, destination, write-enable) from the ID/EX boundary.
- Holds the operation for the class-dependent latency, then presents the result to FP register-file writeback.
- Generates stall and RAW-hazard signals to the pipeline.
- Single outstanding operation; sits between the control decode stage and the FPU/FP register file.

Parameters:
- LAT_ADD, 3, cycles for FADD/FSUB
- LAT_MUL, 4, cycles for FMUL
- LAT_DIV, 12, cycles for FDIV
- LAT_SQRT, 16, cycles for FSQRT
- CNT_W, 5, down-counter width; must hold max latency minus 1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid_i  in  1  decoded FP op present
- issue_ready_o  out  1  sequencer accepts op this cycle
- sel_i  in  5  FPU select code from FPU decoder
- rd_i  in  5  FP destination register
- we_i  in  1  RegWriteF of issued op
- rs1_i, rs2_i, rs3_i  in  5 each  FP sources of the instruction in ID
- rs_fp_i  in  1  instruction in ID reads FP registers
- flush_i  in  1  pipeline flush (kills in-flight op)
- fpu_start_o  out  1  one-cycle start pulse to FPU
- fpu_sel_o  out  5  latched select code to FPU
- busy_o  out  1  op in flight (BUSY or DONE)
- stall_o  out  1  issue_valid_i && !issue_ready_o
- hazard_o  out  1  RAW on pending destination
- wb_valid_o  out  1  result ready for FP register file
- wb_ready_i  in  1  writeback port granted
- wb_rd_o  out  5  destination for writeback
- wb_we_o  out  1  register-file write enable (wb_valid_o && latched we)

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0; latched sel/rd/we 0. Reset mid-operation abandons the op; no writeback is issued.
- Latency class from sel_i:
  - 0 FADD, 1 FSUB → LAT_ADD
  - 2 FMUL → LAT_MUL
  - 3 FDIV → LAT_DIV
  - 4 FSQRT → LAT_SQRT
  - all other codes (sign-inject, min/max, compare, move, convert) → 1
- issue_ready_o = (state==IDLE) || (state==DONE && wb_ready_i). Issue occurs on issue_valid_i && issue_ready_o && !flush_i.
- IDLE:
  - On issue: latch sel/rd/we; fpu_start_o=1 for that cycle only, combinational from issue.
  - Load counter with LAT-1.
  - Go to DONE if LAT==1, else BUSY.
- BUSY:
  - Counter decrements each cycle.
  - When counter==1 at a clock edge, next state is DONE.
  - Result: wb_valid_o first asserts exactly LAT cycles after the issue edge.
- DONE:
  - wb_valid_o=1; wb_rd_o and wb_we_o stable.
  - If wb_ready_i: writeback completes.
  - Simultaneous new issue: go straight to the new op's BUSY/DONE (back-to-back, no bubble); else IDLE.
  - If !wb_ready_i: hold DONE with all outputs stable.
- flush_i:
  - In BUSY or DONE: next state IDLE, wb_valid_o forced 0 that cycle, no register write.
  - Flush with issue_valid_i in the same cycle drops the issue.
  - Flush has priority over wb_ready_i.
- hazard_o = busy_o && latched we && rs_fp_i && (rs1_i, rs2_i or rs3_i equals latched rd). Asserted through DONE, including the writeback cycle (no forwarding path).
- fpu_sel_o holds the latched code from issue until the next issue.
- Counter never wraps: loaded only on issue, decremented only in BUSY.

Decomposition:
- Shared package/header holds:
  - FPU select-code constants (FADD..FSQRT, shared with FPU decoder)
  - state encoding (IDLE=0, BUSY=1, DONE=2)
  - latency-class function mapping sel to latency
- One natural sub-module: fpu_lat_counter (load/decrement/zero-detect down counter).

Test Plan:
- Reset, then issue FMUL (sel=2, rd=5, we=1) at cycle 0 → fpu_start_o pulse at cycle 0; wb_valid_o first high at cycle 4; wb_rd_o=5, wb_we_o=1; issue_ready_o=0 in cycles 1–3.
- Issue FSGNJ (sel=8) with wb_ready_i=1 → wb_valid_o at cycle 1; second FADD issued same cycle → accepted, its wb_valid_o at cycle 4.
- FDIV rd=7 in BUSY; ID presents rs2_i=7, rs_fp_i=1 → hazard_o=1 until the writeback cycle inclusive, 0 the cycle after.
- DONE with wb_ready_i=0 for 3 cycles → wb_valid_o held, issue_valid_i gives stall_o=1; wb_ready_i=1 → completes, stall_o drops.
- Flush at cycle 6 of FSQRT → IDLE next cycle; wb_valid_o never asserts; busy_o=0.
- Assert rst_n=0 asynchronously mid-FDIV → all outputs 0 immediately; no writeback after release.
